vpu_lane_issuer: RTL

Sequencing front end for one VPU lane. Accepts one vector-element operation at a time from the VPU issue stage over a valid/ready request channel. Drives the lane's start/function/operand inputs and waits for the lane's `done` pulse. Returns the result, tag and error flag on a valid/ready response channel. It is the initiator side of the lane's start/done protocol; one instance sits in front of each lane.

---
 rtl/vpu_lane_issuer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vpu_lane_issuer.sv
// vpu_lane_issuer: start/done sequencer in front of one VPU lane.
// Ports: req_* request channel, lane_* start/done, rsp_* response, busy_o.
// Option: VPU_LANE_ISSUER_TIMEOUT_EN adds a TIMEOUT_CYC abort in WAIT.
module vpu_lane_issuer #(
  parameter int OPERAND_WIDTH = 32,
  parameter int SRC_CNT       = 3,
  parameter int FUNC_W        = 9,
  parameter int TAG_W         = 4,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [FUNC_W-1:0]                req_func_i,
  input  logic [SRC_CNT*OPERAND_WIDTH-1:0] req_operand_i,
  input  logic [SRC_CNT-1:0]               req_operand_valid_i,
  input  logic [TAG_W-1:0]                 req_tag_i,
  output logic                             lane_start_o,
  output logic [FUNC_W-1:0]                lane_func_o,
  output logic [SRC_CNT*OPERAND_WIDTH-1:0] lane_operand_o,
  output logic [SRC_CNT-1:0]               lane_operand_valid_o,
  input  logic [OPERAND_WIDTH-1:0]         lane_dout_i,
  input  logic                             lane_done_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [OPERAND_WIDTH-1:0]         rsp_data_o,
  output logic [TAG_W-1:0]                 rsp_tag_o,
  output logic                             rsp_err_o,
  output logic                             busy_o
);
  localparam int OW = SRC_CNT * OPERAND_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_e;

  state_e state_q, state_d;

  logic                     rdy_q, rdy_d;
  logic                     start_q, start_d;
  logic                     vld_q, vld_d;
  logic                     busy_q, busy_d;
  logic [FUNC_W-1:0]        func_q, func_d;
  logic [OW-1:0]            opnd_q, opnd_d;
  logic [SRC_CNT-1:0]       opv_q, opv_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [OPERAND_WIDTH-1:0] data_q, data_d;
  logic                     err_q, err_d;
  logic                     legal;

  assign legal = $onehot(req_func_i);

`ifdef VPU_LANE_ISSUER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire;
  // Last WAIT cycle: the increment here would reach TIMEOUT_CYC.
  assign expire = (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYC;
`endif

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    opnd_d  = opnd_q;
    opv_d   = opv_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef VPU_LANE_ISSUER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          tag_d = req_tag_i;
          if (legal) begin
            func_d  = req_func_i;
            opnd_d  = req_operand_i;
            opv_d   = req_operand_valid_i;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        if (lane_done_i) begin
          data_d  = lane_dout_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
`ifdef VPU_LANE_ISSUER_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      S_WAIT: begin
        // done beats a same-cycle timeout
        if (lane_done_i) begin
          data_d  = lane_dout_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef VPU_LANE_ISSUER_TIMEOUT_EN
        else if (expire) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Lane inputs idle at zero so its output mux yields dout=0, done=0.
    if (state_d == S_IDLE || state_d == S_RESP) begin
      func_d = '0;
      opnd_d = '0;
      opv_d  = '0;
    end
  end

  assign rdy_d   = (state_d == S_IDLE);
  assign start_d = (state_d == S_ISSUE);
  assign vld_d   = (state_d == S_RESP);
  assign busy_d  = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      func_q  <= '0;
      opnd_q  <= '0;
      opv_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef VPU_LANE_ISSUER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      start_q <= start_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      func_q  <= func_d;
      opnd_q  <= opnd_d;
      opv_q   <= opv_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef VPU_LANE_ISSUER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_ready_o          = rdy_q;
  assign lane_start_o         = start_q;
  assign lane_func_o          = func_q;
  assign lane_operand_o       = opnd_q;
  assign lane_operand_valid_o = opv_q;
  assign rsp_valid_o          = vld_q;
  assign rsp_data_o           = data_q;
  assign rsp_tag_o            = tag_q;
  assign rsp_err_o            = err_q;
  assign busy_o               = busy_q;

endmodule
